eth_irq_gateway: RTL and testbench

//  Consumer side of the Ethernet controller interrupt lines. Gates level

---
 rtl/eth_irq_gateway.sv | 110 +++++++++++
 tb/tb_eth_irq_gateway.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/eth_irq_gateway.sv
`default_nettype none
// ============================================================================
// eth_irq_gateway : level-IRQ gateways + priority/threshold claim/complete
// Revision 1.0
// ============================================================================
module eth_irq_gateway #(
   parameter int num_src_p    = 2,
   parameter int prio_width_p = 3,
   parameter int id_width_p   = 2
) (
   input  logic                              clk_i,
   input  logic                              reset_n_i,
   input  logic [num_src_p-1:0]              irq_i,
   input  logic [num_src_p*prio_width_p-1:0] priority_i,
   input  logic [prio_width_p-1:0]           threshold_i,
   input  logic                              claim_v_i,
   output logic [id_width_p-1:0]             claim_id_o,
   output logic                              claim_id_v_o,
   input  logic                              complete_v_i,
   input  logic [id_width_p-1:0]             complete_id_i,
   output logic [num_src_p-1:0]              src_clear_o,
   output logic                              ext_irq_o
);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_PEND    = 2'd1;
   localparam logic [1:0] ST_CLAIMED = 2'd2;

   logic [num_src_p-1:0]    elig;
   logic [num_src_p-1:0]    win_oh;
   logic [id_width_p-1:0]   win_id;
   logic [prio_width_p-1:0] best_prio;
   logic                    found;

   logic                    claim_id_v_q, claim_id_v_d;
   logic [id_width_p-1:0]   claim_id_q, claim_id_d;
   logic [num_src_p-1:0]    src_clear_q, src_clear_d;
   logic                    ext_irq_q, ext_irq_d;

   for (genvar s = 0; s < num_src_p; s++) begin : g_src
      localparam logic [id_width_p-1:0] SRC_ID = id_width_p'(s + 1);

      logic [1:0]              state_q, state_d;
      logic [prio_width_p-1:0] prio;

      assign prio    = priority_i[s*prio_width_p +: prio_width_p];
      assign elig[s] = (state_q == ST_PEND) && (prio != '0) && (prio > threshold_i);

      // irq_i is only looked at in IDLE, so a held line cannot re-pend while claimed
      always_comb begin
         state_d = state_q;
         case (state_q)
            ST_IDLE:    if (irq_i[s]) state_d = ST_PEND;
            ST_PEND:    if (claim_v_i && win_oh[s]) state_d = ST_CLAIMED;
            ST_CLAIMED: if (complete_v_i && (complete_id_i == SRC_ID)) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
         endcase
      end

      always_ff @(posedge clk_i or negedge reset_n_i) begin
         if (!reset_n_i) state_q <= ST_IDLE;
         else            state_q <= state_d;
      end
   end

   // Strict '>' while scanning upward keeps ties on the lowest index
   always_comb begin
      win_oh    = '0;
      win_id    = '0;
      best_prio = '0;
      found     = 1'b0;
      for (int s = 0; s < num_src_p; s++) begin
         if (elig[s] && (!found || (priority_i[s*prio_width_p +: prio_width_p] > best_prio))) begin
            found     = 1'b1;
            best_prio = priority_i[s*prio_width_p +: prio_width_p];
            win_id    = id_width_p'(s + 1);
            win_oh    = '0;
            win_oh[s] = 1'b1;
         end
      end
   end

   always_comb begin
      claim_id_v_d = claim_v_i;
      claim_id_d   = claim_v_i ? win_id : '0;
      src_clear_d  = claim_v_i ? win_oh : '0;
      ext_irq_d    = |elig;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         claim_id_v_q <= 1'b0;
         claim_id_q   <= '0;
         src_clear_q  <= '0;
         ext_irq_q    <= 1'b0;
      end else begin
         claim_id_v_q <= claim_id_v_d;
         claim_id_q   <= claim_id_d;
         src_clear_q  <= src_clear_d;
         ext_irq_q    <= ext_irq_d;
      end
   end

   assign claim_id_v_o = claim_id_v_q;
   assign claim_id_o   = claim_id_q;
   assign src_clear_o  = src_clear_q;
   assign ext_irq_o    = ext_irq_q;

endmodule
`default_nettype wire

// File: tb/tb_eth_irq_gateway.sv
`default_nettype none
// ============================================================================
// tb_eth_irq_gateway : table vectors, reset sequence and randomized model check
// Revision 1.0
// ============================================================================
module tb_eth_irq_gateway;

   localparam int NS = 2;
   localparam int PW = 3;
   localparam int IW = 2;

   logic              clk = 1'b0;
   logic              reset_n;
   logic [NS-1:0]     irq;
   logic [NS*PW-1:0]  prio;
   logic [PW-1:0]     thr;
   logic              cv;
   logic              compv;
   logic [IW-1:0]     cid;
   logic [IW-1:0]     claim_id;
   logic              claim_id_v;
   logic [NS-1:0]     src_clear;
   logic              ext_irq;

   always #5 clk = ~clk;

   eth_irq_gateway #(
      .num_src_p    (NS),
      .prio_width_p (PW),
      .id_width_p   (IW)
   ) dut (
      .clk_i         (clk),
      .reset_n_i     (reset_n),
      .irq_i         (irq),
      .priority_i    (prio),
      .threshold_i   (thr),
      .claim_v_i     (cv),
      .claim_id_o    (claim_id),
      .claim_id_v_o  (claim_id_v),
      .complete_v_i  (compv),
      .complete_id_i (cid),
      .src_clear_o   (src_clear),
      .ext_irq_o     (ext_irq)
   );

   typedef struct {
      logic [1:0] irq;
      logic [5:0] prio;
      logic [2:0] thr;
      logic       cv;
      logic       compv;
      logic [1:0] cid;
      logic       v;
      logic [1:0] id;
      logic [1:0] clr;
      logic       xirq;
   } vec_t;

   vec_t tbl[22];

   int n_chk  = 0;
   int n_fail = 0;

   // Model state per source: 0 = idle, 1 = pending, 2 = claimed
   int         mst[NS];
   logic       exp_v;
   logic [1:0] exp_id;
   logic [1:0] exp_clr;
   logic       exp_irq;

   task automatic check(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, ".v"},   int'(claim_id_v), int'(exp_v));
      check({tag, ".id"},  int'(claim_id),   int'(exp_id));
      check({tag, ".clr"}, int'(src_clear),  int'(exp_clr));
      check({tag, ".irq"}, int'(ext_irq),    int'(exp_irq));
   endtask

   // Called at a negedge; returns at the next negedge with outputs settled.
   task automatic cycle(input logic [1:0] i_irq, input logic [5:0] i_prio,
                        input logic [2:0] i_thr, input logic i_cv,
                        input logic i_compv, input logic [1:0] i_cid);
      int p[NS];
      int nxt[NS];
      int best;
      irq = i_irq; prio = i_prio; thr = i_thr;
      cv = i_cv; compv = i_compv; cid = i_cid;
      for (int s = 0; s < NS; s++) p[s] = int'((i_prio >> (s*PW)) & 6'h7);
      best = -1;
      for (int s = 0; s < NS; s++)
         if (mst[s] == 1 && p[s] != 0 && p[s] > int'(i_thr) && (best < 0 || p[s] > p[best]))
            best = s;
      exp_v   = i_cv;
      exp_id  = (i_cv && best >= 0) ? 2'(best + 1) : 2'd0;
      exp_clr = (i_cv && best >= 0) ? 2'(1 << best) : 2'd0;
      exp_irq = (best >= 0);
      for (int s = 0; s < NS; s++) begin
         nxt[s] = mst[s];
         if (mst[s] == 0 && i_irq[s]) nxt[s] = 1;
         if (mst[s] == 1 && i_cv && best == s) nxt[s] = 2;
         if (mst[s] == 2 && i_compv && int'(i_cid) == s + 1) nxt[s] = 0;
      end
      @(posedge clk);
      #1;
      for (int s = 0; s < NS; s++) mst[s] = nxt[s];
      @(negedge clk);
   endtask

   initial begin
      //          irq    prio   thr   cv compv cid   v  id  clr  xirq
      tbl[0]  = '{2'b01, 6'o12, 3'd0, 0, 0, 2'd0,   0, 0, 2'b00, 0};
      tbl[1]  = '{2'b01, 6'o12, 3'd0, 0, 0, 2'd0,   0, 0, 2'b00, 1};
      tbl[2]  = '{2'b01, 6'o12, 3'd0, 1, 0, 2'd0,   1, 1, 2'b01, 1};
      tbl[3]  = '{2'b01, 6'o12, 3'd0, 0, 0, 2'd0,   0, 0, 2'b00, 0};
      tbl[4]  = '{2'b01, 6'o12, 3'd0, 0, 0, 2'd0,   0, 0, 2'b00, 0};
      tbl[5]  = '{2'b01, 6'o12, 3'd0, 0, 1, 2'd1,   0, 0, 2'b00, 0};
      tbl[6]  = '{2'b01, 6'o12, 3'd0, 0, 0, 2'd0,   0, 0, 2'b00, 0};
      tbl[7]  = '{2'b01, 6'o12, 3'd0, 0, 0, 2'd0,   0, 0, 2'b00, 1};
      tbl[8]  = '{2'b11, 6'o33, 3'd0, 1, 0, 2'd0,   1, 1, 2'b01, 1};
      tbl[9]  = '{2'b11, 6'o33, 3'd0, 1, 0, 2'd0,   1, 2, 2'b10, 1};
      tbl[10] = '{2'b11, 6'o33, 3'd0, 0, 0, 2'd0,   0, 0, 2'b00, 0};
      tbl[11] = '{2'b11, 6'o33, 3'd0, 1, 1, 2'd1,   1, 0, 2'b00, 0};
      tbl[12] = '{2'b11, 6'o33, 3'd0, 0, 1, 2'd3,   0, 0, 2'b00, 0};
      tbl[13] = '{2'b11, 6'o33, 3'd0, 0, 1, 2'd0,   0, 0, 2'b00, 1};
      tbl[14] = '{2'b11, 6'o33, 3'd3, 1, 0, 2'd0,   1, 0, 2'b00, 0};
      tbl[15] = '{2'b11, 6'o33, 3'd2, 0, 0, 2'd0,   0, 0, 2'b00, 1};
      tbl[16] = '{2'b11, 6'o33, 3'd2, 1, 1, 2'd2,   1, 1, 2'b01, 1};
      tbl[17] = '{2'b10, 6'o23, 3'd2, 0, 0, 2'd0,   0, 0, 2'b00, 0};
      tbl[18] = '{2'b10, 6'o23, 3'd2, 1, 0, 2'd0,   1, 0, 2'b00, 0};
      tbl[19] = '{2'b10, 6'o23, 3'd1, 0, 0, 2'd0,   0, 0, 2'b00, 1};
      tbl[20] = '{2'b10, 6'o23, 3'd1, 1, 1, 2'd1,   1, 2, 2'b10, 1};
      tbl[21] = '{2'b00, 6'o23, 3'd1, 0, 0, 2'd0,   0, 0, 2'b00, 0};

      for (int s = 0; s < NS; s++) mst[s] = 0;
      reset_n = 1'b0;
      irq = '0; prio = '0; thr = '0; cv = 1'b0; compv = 1'b0; cid = '0;
      repeat (2) @(negedge clk);
      check("reset.v",   int'(claim_id_v), 0);
      check("reset.id",  int'(claim_id),   0);
      check("reset.clr", int'(src_clear),  0);
      check("reset.irq", int'(ext_irq),    0);
      reset_n = 1'b1;
      @(negedge clk);

      for (int k = 0; k < 22; k++) begin
         cycle(tbl[k].irq, tbl[k].prio, tbl[k].thr, tbl[k].cv, tbl[k].compv, tbl[k].cid);
         check($sformatf("vec%0d.v", k),   int'(claim_id_v), int'(tbl[k].v));
         check($sformatf("vec%0d.id", k),  int'(claim_id),   int'(tbl[k].id));
         check($sformatf("vec%0d.clr", k), int'(src_clear),  int'(tbl[k].clr));
         check($sformatf("vec%0d.irq", k), int'(ext_irq),    int'(tbl[k].xirq));
      end

      // Reset asserted while both sources are claimed and a clear pulse is live
      cycle(2'b01, 6'o33, 3'd0, 0, 0, 2'd0);
      check_model("pre_rst0");
      cycle(2'b01, 6'o33, 3'd0, 1, 0, 2'd0);
      check("pre_rst.id",  int'(claim_id),  1);
      check("pre_rst.clr", int'(src_clear), 1);
      irq = 2'b11;
      #2;
      reset_n = 1'b0;
      #1;
      check("mid_rst.v",   int'(claim_id_v), 0);
      check("mid_rst.id",  int'(claim_id),   0);
      check("mid_rst.clr", int'(src_clear),  0);
      check("mid_rst.irq", int'(ext_irq),    0);
      for (int s = 0; s < NS; s++) mst[s] = 0;
      @(negedge clk);
      reset_n = 1'b1;
      cycle(2'b11, 6'o33, 3'd0, 0, 0, 2'd0);
      check_model("post_rst0");
      cycle(2'b11, 6'o33, 3'd0, 0, 0, 2'd0);
      check("post_rst1.irq", int'(ext_irq), 1);
      cycle(2'b11, 6'o33, 3'd0, 1, 0, 2'd0);
      check("post_rst2.id", int'(claim_id), 1);
      check_model("post_rst2");

      for (int k = 0; k < 400; k++) begin
         cycle(2'($urandom_range(0, 3)),
               6'($urandom_range(0, 63)),
               3'($urandom_range(0, 4)),
               1'($urandom_range(0, 1)),
               ($urandom_range(0, 9) < 4),
               2'($urandom_range(0, 3)));
         check_model($sformatf("rnd%0d", k));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
